// File: rtl/scpu_ctl_pkg.sv
// Shared encodings for the SCPU multi-cycle control unit: opcodes, functs,
// FSM states, and datapath select codes.
package scpu_ctl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] RDST_RT  = 2'b00;
  localparam logic [1:0] RDST_RD  = 2'b01;
  localparam logic [1:0] RDST_R31 = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  // Successor of DECODE; FETCH here means the instruction is unsupported.
  function automatic state_t decode_next(input logic [5:0] opcode, input logic [5:0] funct);
    state_t nxt;
    nxt = S_FETCH;
    case (opcode)
      OP_LW, OP_SW:    nxt = S_MEMADR;
      OP_BEQ, OP_BNE:  nxt = S_BRANCH;
      OP_ADDI, OP_XORI: nxt = S_IEXEC;
      OP_J:            nxt = S_JUMP;
      OP_JAL:          nxt = S_JAL;
      OP_RTYPE: begin
        case (funct)
          FN_JR:                          nxt = S_JR;
          FN_ADD, FN_SUB, FN_XOR, FN_SLT: nxt = S_EXEC;
          default:                        nxt = S_FETCH;
        endcase
      end
      default: nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] funct);
    logic [2:0] ctl;
    case (funct)
      FN_SUB:  ctl = ALU_SUB;
      FN_XOR:  ctl = ALU_XOR;
      FN_SLT:  ctl = ALU_SLT;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle SCPU control unit: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and write enables, with stretched memory states.
module mc_control_fsm
  import scpu_ctl_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_we,
  output logic       iord,
  output logic       reg_we,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       ext_zero,
  output logic [2:0] alu_ctl,
  output logic [1:0] pcsrc,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t           state;
  state_t           dec_next;
  state_t           st_dec;
  logic [CNT_W-1:0] cnt;
  logic             mem_last;
  logic             strobe_en;

  assign dec_next  = decode_next(opcode, funct);
  assign mem_last  = (cnt == CNT_W'(MEM_LATENCY - 1));
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_last) begin
            state <= S_DECODE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DECODE: state <= dec_next;
        S_MEMADR: state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (mem_last) begin
            state <= S_MEMWB;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MEMWR: begin
          if (mem_last) begin
            state <= S_FETCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EXEC:  state <= S_RWB;
        S_IEXEC: state <= S_IWB;
        default: begin
          state <= S_FETCH;
          cnt   <= '0;
        end
      endcase
    end
  end

  // During reset the outputs show FETCH selects with every strobe held low.
  assign st_dec    = reset ? S_FETCH : state;
  assign strobe_en = !reset;

  always_comb begin
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    reg_we   = 1'b0;
    regdst   = RDST_RT;
    memtoreg = M2R_ALUOUT;
    alusrca  = 1'b0;
    alusrcb  = SRCB_RT;
    ext_zero = 1'b0;
    alu_ctl  = ALU_ADD;
    pcsrc    = PCSRC_ALU;
    illegal  = 1'b0;
    case (st_dec)
      S_FETCH: begin
        alusrcb = SRCB_FOUR;
        ir_we   = strobe_en && mem_last;
        pc_we   = strobe_en && mem_last;
      end
      S_DECODE: begin
        alusrcb = SRCB_BOFS;
        illegal = strobe_en && (dec_next == S_FETCH);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        reg_we   = strobe_en;
        memtoreg = M2R_MDR;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_we = strobe_en && mem_last;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        alu_ctl = funct_alu(funct);
      end
      S_RWB: begin
        reg_we = strobe_en;
        regdst = RDST_RD;
      end
      S_IEXEC: begin
        alusrca  = 1'b1;
        alusrcb  = SRCB_IMM;
        ext_zero = (opcode == OP_XORI);
        alu_ctl  = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
      end
      S_IWB: reg_we = strobe_en;
      S_BRANCH: begin
        alusrca = 1'b1;
        alu_ctl = ALU_SUB;
        pcsrc   = PCSRC_ALUOUT;
        pc_we   = strobe_en && ((opcode == OP_BNE) ? !zero : zero);
      end
      S_JUMP: begin
        pcsrc = PCSRC_JUMP;
        pc_we = strobe_en;
      end
      S_JAL: begin
        pcsrc    = PCSRC_JUMP;
        pc_we    = strobe_en;
        reg_we   = strobe_en;
        regdst   = RDST_R31;
        memtoreg = M2R_PC;
      end
      S_JR: begin
        pcsrc = PCSRC_RS;
        pc_we = strobe_en;
      end
      default: ;
    endcase
  end

endmodule
